// File: rtl/cache_pkg.sv
// Shared state encoding, line metadata and geometry helpers for the
// N-way write-back data cache.
package cache_pkg;

  // Widest tag any legal geometry needs; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 30;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } cache_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int calc_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int num_sets);
    return addr_w - 2 - $clog2(num_sets);
  endfunction

  function automatic int calc_age_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

endpackage

// File: rtl/lru_ctrl.sv
// True-LRU age tracking: one age per way per set, touch update and the
// max-age victim for the currently indexed set.
module lru_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  localparam int IDX_W = calc_idx_w(NUM_SETS),
  localparam int AGE_W = calc_age_w(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_touch,
  input  logic [AGE_W-1:0] i_touch_way,
  output logic [AGE_W-1:0] o_victim
);

  logic [AGE_W-1:0] r_age [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] w_touch_age;

  assign w_touch_age = r_age[i_idx][i_touch_way];

  // Ages younger than the touched way grow older; the touched way becomes newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_age[s][w] <= AGE_W'(w);
        end
      end
    end else if (i_touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == i_touch_way) begin
          r_age[i_idx][w] <= '0;
        end else if (r_age[i_idx][w] < w_touch_age) begin
          r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
        end
      end
    end
  end

  // Ages are a permutation, so exactly one way holds the maximum.
  always_comb begin
    o_victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_age[i_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
        o_victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with miss FSM.
// Define CACHE_PERF_CNT_EN to build the saturating hit/miss/writeback counters.
module nway_wb_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_valid,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt,
  output logic [31:0]       o_wb_cnt
);

  localparam int IDX_W = calc_idx_w(NUM_SETS);
  localparam int TAG_W = calc_tag_w(ADDR_W, NUM_SETS);
  localparam int AGE_W = calc_age_w(NUM_WAYS);

  cache_state_e      r_state, w_next;
  line_meta_t        r_meta [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] r_data [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]  r_vic_way, w_hit_way, w_inv_way, w_lru_way, w_victim, w_touch_way;
  logic              w_hit, w_has_inv, w_touch, w_store_hit, w_fill, w_miss;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag, w_vic_tag;
  line_meta_t        w_vic_meta;
  logic              w_unused;

  assign w_idx       = i_cpu_addr[2+IDX_W-1:2];
  assign w_tag       = i_cpu_addr[ADDR_W-1:2+IDX_W];
  assign w_unused    = ^i_cpu_addr[1:0];
  assign w_victim    = w_has_inv ? w_inv_way : w_lru_way;
  assign w_vic_meta  = r_meta[w_idx][w_victim];
  assign w_vic_tag   = r_meta[w_idx][r_vic_way].tag[TAG_W-1:0];
  assign w_store_hit = (r_state == IDLE) && i_cpu_req && w_hit && i_cpu_we;
  assign w_miss      = (r_state == IDLE) && i_cpu_req && !w_hit;
  assign w_fill      = (r_state == REFILL) && i_mem_valid;
  assign o_stall     = i_cpu_req & ~o_cpu_ready;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_meta[w_idx][w].valid && (r_meta[w_idx][w].tag == TAG_MAX_W'(w_tag))) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!r_meta[w_idx][w].valid) begin
        w_has_inv = 1'b1;
        w_inv_way = AGE_W'(w);
      end
    end
  end

  lru_ctrl #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (w_idx),
    .i_touch     (w_touch),
    .i_touch_way (w_touch_way),
    .o_victim    (w_lru_way)
  );

  // Miss FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, CPU response and memory request.
  always_comb begin
    w_next      = r_state;
    o_cpu_ready = 1'b0;
    o_cpu_rdata = '0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    w_touch     = 1'b0;
    w_touch_way = w_hit_way;
    case (r_state)
      IDLE: begin
        if (i_cpu_req && w_hit) begin
          o_cpu_ready = 1'b1;
          o_cpu_rdata = r_data[w_idx][w_hit_way];
          w_touch     = 1'b1;
        end else if (i_cpu_req) begin
          w_next = (w_vic_meta.valid && w_vic_meta.dirty) ? WRITEBACK : REFILL;
        end else begin
          w_next = IDLE;
        end
      end
      WRITEBACK: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {w_vic_tag, w_idx, 2'b00};
        o_mem_wdata = r_data[w_idx][r_vic_way];
        w_next      = i_mem_valid ? REFILL : WRITEBACK;
      end
      REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {w_tag, w_idx, 2'b00};
        if (i_mem_valid) begin
          w_next      = IDLE;
          w_touch     = 1'b1;
          w_touch_way = r_vic_way;
        end else begin
          w_next = REFILL;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Victim is frozen at miss detection; the access is held stable until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vic_way <= '0;
    end else if (w_miss) begin
      r_vic_way <= w_victim;
    end
  end

  // Line metadata: only valid/dirty are cleared by reset, tags are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_meta[s][w].valid <= 1'b0;
          r_meta[s][w].dirty <= 1'b0;
        end
      end
    end else if (w_store_hit) begin
      r_meta[w_idx][w_hit_way].dirty <= 1'b1;
    end else if (w_fill) begin
      r_meta[w_idx][r_vic_way] <= line_meta_t'{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX_W'(w_tag)};
    end
  end

  // Data array, no reset.
  always_ff @(posedge clk) begin
    if (w_store_hit) begin
      r_data[w_idx][w_hit_way] <= i_cpu_wdata;
    end else if (w_fill) begin
      r_data[w_idx][r_vic_way] <= i_mem_rdata;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
      r_wb_cnt   <= 32'd0;
    end else begin
      if (o_cpu_ready && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      if ((r_state == WRITEBACK) && i_mem_valid && (r_wb_cnt != 32'hFFFF_FFFF)) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;
`else
  assign o_hit_cnt  = 32'd0;
  assign o_miss_cnt = 32'd0;
  assign o_wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_nway_wb_cache.sv
// Randomised bench for nway_wb_cache: a 2-way and a 4-way instance checked
// against a recency-list cache model and a word-addressed memory model.
module tb_nway_wb_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req   [2] = '{1'b0, 1'b0};
  logic        cpu_we    [2] = '{1'b0, 1'b0};
  logic [31:0] cpu_addr  [2] = '{32'd0, 32'd0};
  logic [31:0] cpu_wdata [2] = '{32'd0, 32'd0};
  logic [31:0] cpu_rdata [2];
  logic        cpu_ready [2];
  logic        stall     [2];
  logic        mem_req   [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2] = '{32'd0, 32'd0};
  logic        mem_valid [2] = '{1'b0, 1'b0};
  logic [31:0] hit_cnt   [2];
  logic [31:0] miss_cnt  [2];
  logic [31:0] wb_cnt    [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_timeouts = 0;
  int lat = 0;
  int mem_cnt [2] = '{0, 0};

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    bit          dirty;
  } line_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  line_t       lines [2][4][$];    // per set, most recently used first
  tx_t         txq [$];
  logic [31:0] bmem [logic [32:0]];
  logic [31:0] rmem [logic [32:0]];
  int          exp_hit [2] = '{0, 0};
  int          exp_miss[2] = '{0, 0};
  int          exp_wb  [2] = '{0, 0};

  always #5 clk = ~clk;

  nway_wb_cache #(.NUM_SETS(4), .NUM_WAYS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req[0]), .i_cpu_we(cpu_we[0]), .i_cpu_addr(cpu_addr[0]), .i_cpu_wdata(cpu_wdata[0]),
    .o_cpu_rdata(cpu_rdata[0]), .o_cpu_ready(cpu_ready[0]), .o_stall(stall[0]),
    .o_mem_req(mem_req[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]),
    .i_mem_rdata(mem_rdata[0]), .i_mem_valid(mem_valid[0]),
    .o_hit_cnt(hit_cnt[0]), .o_miss_cnt(miss_cnt[0]), .o_wb_cnt(wb_cnt[0])
  );

  nway_wb_cache #(.NUM_SETS(4), .NUM_WAYS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req[1]), .i_cpu_we(cpu_we[1]), .i_cpu_addr(cpu_addr[1]), .i_cpu_wdata(cpu_wdata[1]),
    .o_cpu_rdata(cpu_rdata[1]), .o_cpu_ready(cpu_ready[1]), .o_stall(stall[1]),
    .o_mem_req(mem_req[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]),
    .i_mem_rdata(mem_rdata[1]), .i_mem_valid(mem_valid[1]),
    .o_hit_cnt(hit_cnt[1]), .o_miss_cnt(miss_cnt[1]), .o_wb_cnt(wb_cnt[1])
  );

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] bmem_read(input logic [32:0] k);
    if (bmem.exists(k)) return bmem[k];
    return mem_init(k[31:0]);
  endfunction

  function automatic logic [31:0] rmem_read(input logic [32:0] k);
    if (rmem.exists(k)) return rmem[k];
    return mem_init(k[31:0]);
  endfunction

  // Memory: completes a request after it has been pending for lat cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mem_valid[d] = 1'b0;
      if (mem_req[d]) begin
        mem_cnt[d] = mem_cnt[d] + 1;
        if (mem_cnt[d] == lat + 1) begin
          mem_cnt[d] = 0;
          mem_valid[d] = 1'b1;
          if (mem_we[d]) begin
            bmem[{1'(d), mem_addr[d]}] = mem_wdata[d];
            txq.push_back(tx_t'{1'b1, mem_addr[d], mem_wdata[d]});
          end else begin
            mem_rdata[d] = bmem_read({1'(d), mem_addr[d]});
            txq.push_back(tx_t'{1'b0, mem_addr[d], mem_rdata[d]});
          end
        end
      end else begin
        mem_cnt[d] = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) lines[d][s].delete();
      exp_hit[d] = 0;
      exp_miss[d] = 0;
      exp_wb[d] = 0;
    end
    txq.delete();
  endtask

  task automatic pulse_reset();
    cpu_req[0] = 1'b0;
    cpu_req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic check_counters(input int d);
`ifdef CACHE_PERF_CNT_EN
    check_eq("hit_cnt", hit_cnt[d], 32'(exp_hit[d]));
    check_eq("miss_cnt", miss_cnt[d], 32'(exp_miss[d]));
    check_eq("wb_cnt", wb_cnt[d], 32'(exp_wb[d]));
`else
    check_eq("hit_cnt", hit_cnt[d], 32'd0);
    check_eq("miss_cnt", miss_cnt[d], 32'd0);
    check_eq("wb_cnt", wb_cnt[d], 32'd0);
`endif
  endtask

  // One CPU access on instance d, called on a falling edge; returns on a falling edge.
  task automatic access(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold);
    logic [29:0] word;
    int          set;
    int          pos;
    int          ways;
    int          exp_cyc;
    int          cyc;
    logic        first_stall;
    logic [31:0] exp_rdata;
    line_t       ln;
    line_t       victim;
    tx_t         exp_tx [$];

    word = addr[31:2];
    set  = int'(word[1:0]);
    ways = (d == 0) ? 2 : 4;
    pos  = -1;
    for (int i = 0; i < lines[d][set].size(); i++) begin
      if (lines[d][set][i].word == word) pos = i;
    end
    if (pos >= 0) begin
      ln = lines[d][set][pos];
      lines[d][set].delete(pos);
      exp_cyc = 0;
    end else begin
      exp_miss[d]++;
      exp_cyc = lat + 2;
      if (lines[d][set].size() == ways) begin
        victim = lines[d][set].pop_back();
        if (victim.dirty) begin
          exp_tx.push_back(tx_t'{1'b1, {victim.word, 2'b00}, victim.data});
          rmem[{1'(d), victim.word, 2'b00}] = victim.data;
          exp_wb[d]++;
          exp_cyc = exp_cyc + lat + 1;
        end
      end
      ln.word  = word;
      ln.data  = rmem_read({1'(d), word, 2'b00});
      ln.dirty = 1'b0;
      exp_tx.push_back(tx_t'{1'b0, {word, 2'b00}, ln.data});
    end
    exp_hit[d]++;
    exp_rdata = ln.data;
    if (we) begin
      ln.data  = wdata;
      ln.dirty = 1'b1;
    end
    lines[d][set].push_front(ln);

    cpu_req[d]   = 1'b1;
    cpu_we[d]    = we;
    cpu_addr[d]  = addr;
    cpu_wdata[d] = wdata;
    cyc = 0;
    #1;
    first_stall = stall[d];
    while (!cpu_ready[d] && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(exp_cyc));
    check_eq("stall_first", {31'd0, first_stall}, {31'd0, exp_cyc != 0});
    check_eq("stall_done", {31'd0, stall[d]}, 32'd0);
    if (!we) check_eq("rdata", cpu_rdata[d], exp_rdata);
    @(negedge clk);
    if (!hold) cpu_req[d] = 1'b0;
    check_eq("mem_tx_count", 32'(txq.size()), 32'(exp_tx.size()));
    for (int i = 0; i < txq.size() && i < exp_tx.size(); i++) begin
      check_eq("mem_tx_we", {31'd0, txq[i].we}, {31'd0, exp_tx[i].we});
      check_eq("mem_tx_addr", txq[i].addr, exp_tx[i].addr);
      check_eq("mem_tx_data", txq[i].data, exp_tx[i].data);
    end
    txq.delete();
    if (cyc >= 200) begin
      n_timeouts++;
      if (n_timeouts >= 3) finish_sim();
    end
  endtask

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    finish_sim();
  end

  initial begin
    logic [31:0] a;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", {31'd0, cpu_ready[d]}, 32'd0);
      check_eq("rst_mem_req", {31'd0, mem_req[d]}, 32'd0);
      check_eq("rst_stall", {31'd0, stall[d]}, 32'd0);
      check_eq("rst_rdata", cpu_rdata[d], 32'd0);
      check_eq("rst_mem_addr", mem_addr[d], 32'd0);
      check_counters(d);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();

    // Cold load with latency 3, then a repeat hit, then a store hit.
    lat = 3;
    access(0, 1'b0, 32'h100, 32'd0, 1'b0);
    check_counters(0);
    access(0, 1'b0, 32'h100, 32'd0, 1'b0);
    access(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h100, 32'd0, 1'b0);
    check_counters(0);

    // Reset while a refill is outstanding.
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h200; cpu_wdata[0] = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_rst_mem_req", {31'd0, mem_req[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mem_req_drop", {31'd0, mem_req[0]}, 32'd0);
    check_eq("rst_mid_ready", {31'd0, cpu_ready[0]}, 32'd0);
    cpu_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    access(0, 1'b0, 32'h200, 32'd0, 1'b0);
    access(0, 1'b0, 32'h100, 32'd0, 1'b0);

    // Dirty eviction in set 0 of the 2-way cache.
    pulse_reset();
    lat = 2;
    access(0, 1'b1, 32'h000, 32'h1111_0000, 1'b0);
    access(0, 1'b1, 32'h010, 32'h2222_0010, 1'b0);
    access(0, 1'b0, 32'h020, 32'd0, 1'b0);
    check_counters(0);
    access(0, 1'b0, 32'h000, 32'd0, 1'b0);

    // 4-way LRU: fill A..D, touch A, miss on E evicts B.
    lat = 1;
    for (int i = 0; i < 4; i++) access(1, 1'b0, 32'(i * 16), 32'd0, 1'b0);
    access(1, 1'b0, 32'h000, 32'd0, 1'b0);
    access(1, 1'b0, 32'h040, 32'd0, 1'b0);
    access(1, 1'b0, 32'h000, 32'd0, 1'b0);
    access(1, 1'b0, 32'h010, 32'd0, 1'b0);
    check_counters(1);

    // Back-to-back hits across four sets with the request held.
    for (int i = 0; i < 4; i++) access(0, 1'b0, 32'h300 + 32'(i * 4), 32'd0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        access(0, 1'(i % 2), 32'h300 + 32'(i * 4), $urandom, !(r == 2 && i == 3));
      end
    end

    // Random traffic over both geometries.
    for (int n = 0; n < 300; n++) begin
      int d;
      d   = int'($urandom_range(0, 1));
      lat = int'($urandom_range(0, 3));
      a   = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 20);
      access(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    check_counters(0);
    check_counters(1);

    finish_sim();
  end

endmodule

// File: doc/nway_wb_cache.md
Name: nway_wb_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the pipeline MEM stage and data memory. One 32-bit word per line, true-LRU replacement, and an explicit miss FSM with a request/valid handshake to memory. It stalls the pipeline until the access completes. Successor to the fixed 2-way/4-set miss cache: it adds configurable geometry, LRU, write hits and proper dirty eviction.

Parameters:
- NUM_SETS, 4, number of sets; power of two, ≥2.
- NUM_WAYS, 2, associativity; power of two, 2..8.
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; fixed at 32 in this generation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid when cpu_ready.
- cpu_ready  out  1  access completes this cycle.
- stall  out  1  equals cpu_req & ~cpu_ready.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  32  writeback data.
- mem_rdata  in  32  refill data.
- mem_valid  in  1  memory completes the current request.
- hit_cnt, miss_cnt, wb_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Address split: index = cpu_addr[2+IDX_W-1:2] with IDX_W = log2(NUM_SETS); tag = cpu_addr[ADDR_W-1:2+IDX_W].
- Reset (async): state IDLE. All valid, dirty and LRU age bits cleared; ages initialised to the way number. All outputs 0. Tag and data arrays are not reset. Reset mid-miss aborts the miss and drops mem_req immediately; memory must tolerate the abort.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, cpu_req and hit:
  - cpu_ready = 1 combinationally.
  - Load: cpu_rdata = data of the hitting way, same cycle.
  - Store: data is written at the clock edge and dirty is set.
  - LRU is updated at the edge.
- IDLE, cpu_req and miss:
  - cpu_ready = 0; the victim is latched.
  - Victim choice: the lowest-indexed invalid way; otherwise the way with the maximum age.
  - Victim valid and dirty → WRITEBACK; otherwise → REFILL.
- WRITEBACK:
  - Drives mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim data.
  - All signals held stable until mem_valid, then → REFILL.
- REFILL:
  - Drives mem_req = 1, mem_we = 0, mem_addr = {tag, index, 2'b00}.
  - On mem_valid, at the edge: victim gets tag, valid = 1, data = mem_rdata, dirty = 0, and LRU is updated; → IDLE.
- After a refill, the access is re-evaluated in IDLE and hits. Latency in cycles from miss detection to cpu_ready:
  - Clean miss: 1 + memory latency + 1.
  - Dirty miss: adds the writeback latency.
- CPU rules: cpu_req, cpu_we, cpu_addr and cpu_wdata must stay stable while stall = 1.
- Memory rules: mem_valid is ignored while mem_req = 0. The block never asserts mem_req in IDLE.
- LRU (per set, log2(NUM_WAYS)-bit ages) on a touch of way w: ages less than age[w] increment, then age[w] = 0. Ages always form a permutation of 0..NUM_WAYS-1.
- cpu_req = 0: no state, LRU or array change.
- Simultaneous events: two ways matching the same tag cannot occur; the lowest way wins if it does. A store that misses completes as a store hit in the cycle after the refill (write-allocate).

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined:
  - hit_cnt increments on each IDLE hit with cpu_ready.
  - miss_cnt increments on each IDLE→WRITEBACK/REFILL transition.
  - wb_cnt increments on each WRITEBACK completion.
  - All three saturate at 2^32-1 and clear on rst.
- Undefined: the three ports are tied to 0 and no counter flops exist.

Decomposition:
- Package cache_pkg holds:
  - the cache_state_e enum (IDLE, WRITEBACK, REFILL);
  - localparam helper functions for IDX_W, TAG_W and AGE_W;
  - a line_meta_t struct {valid, dirty, tag}.
- Sub-module lru_ctrl: per-set age storage, the touch-update and the victim (max-age) output, parametrised by NUM_SETS and NUM_WAYS.

Test Plan:
- Cold load 0x100, memory latency 3 → one REFILL read at 0x100; cpu_ready 5 cycles after the request; repeat load hits in 0 wait cycles; miss_cnt = 1, hit_cnt = 1.
- Store 0xDEADBEEF to 0x100 after fill → hit, dirty set, no mem_req; load 0x100 returns 0xDEADBEEF.
- Default geometry, stores to 0x000, 0x010, then a load of 0x020 (all set 0) → WRITEBACK of 0x000 with data intact, then REFILL of 0x020; wb_cnt = 1.
- NUM_WAYS = 4: fill ways with A, B, C, D, touch A, then miss on E → B evicted, not A.
- Assert rst during REFILL with mem_valid pending → mem_req = 0 immediately; all lines invalid; next access to the same address misses.
- Back-to-back hits in 4 different sets with cpu_req held → cpu_ready every cycle, stall never asserted.
